filter_pack_ctrl: RTL and testbench

// Flow controller and packer that sits behind the 4-lane valid-compaction filter.
// - Admits upstream beats into the filter only when buffer space is guaranteed.
//   The filter has no backpressure, so this is a credit gate.
// - Collects the compacted words into a circular buffer.
// - Emits dense 4-word beats on a valid/ready interface.
// - On the last beat, drains the remainder as a partial beat tagged out_last.

---
 rtl/filter_pack_ctrl.sv | 162 ++++++++++++++++
 tb/tb_filter_pack_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_pack_ctrl.sv
//------------------------------------------------------------------------------
// filter_pack_ctrl: credit gate and 4-word packer behind the lane-compaction filter
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module filter_pack_ctrl #(
  parameter int WIDTH      = 64,
  parameter int BUF_WORDS  = 16,
  parameter int FILTER_LAT = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         up_valid,
  input  logic                         up_last,
  output logic                         up_ready,
  output logic                         filt_issue,
  input  logic [3:0]                   filt_valid,
  input  logic [4*WIDTH-1:0]           filt_word,
  input  logic                         filt_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [4*WIDTH-1:0]           out_word,
  output logic [3:0]                   out_mask,
  output logic                         out_last,
  output logic                         done,
  output logic [$clog2(BUF_WORDS):0]   occupancy
);

  localparam int PW = $clog2(BUF_WORDS);
  localparam int CW = PW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            state;
  logic [FILTER_LAT-1:0] pipe;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  last_issued;
  logic [WIDTH-1:0]      buf_mem [BUF_WORDS];

  logic                  arrival;
  logic [31:0]           in_flight;
  logic                  credit_ok;
  logic [2:0]            wr_n;
  logic [2:0]            pop_n;
  logic                  handshake;
  logic                  full;
  logic [3:0]            part_mask;
  logic [4*WIDTH-1:0]    rd_word;

  function automatic logic [2:0] pop4(input logic [3:0] v);
    pop4 = {2'b0, v[0]} + {2'b0, v[1]} + {2'b0, v[2]} + {2'b0, v[3]};
  endfunction

  assign arrival = pipe[FILTER_LAT-1];

  // Each in-flight beat reserves a worst-case 4 words, since the filter cannot stall.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < FILTER_LAT; i++) begin
      in_flight = in_flight + 32'(pipe[i]);
    end
  end

  assign credit_ok  = (32'(count) + (in_flight << 2) + 32'd4) <= 32'(BUF_WORDS);
  assign up_ready   = (state == S_RUN) && !last_issued && credit_ok;
  assign filt_issue = up_valid && up_ready;
  assign wr_n       = arrival ? pop4(filt_valid) : 3'd0;

  generate
    if (FILTER_LAT == 1) begin : g_pipe_single
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pipe <= '0;
        else        pipe <= filt_issue;
      end
    end else begin : g_pipe_shift
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pipe <= '0;
        else        pipe <= {pipe[FILTER_LAT-2:0], filt_issue};
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (arrival) begin
      for (int i = 0; i < 4; i++) begin
        if (3'(i) < wr_n) buf_mem[wr_ptr + PW'(i)] <= filt_word[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rd_word[i*WIDTH +: WIDTH] = buf_mem[rd_ptr + PW'(i)];
    end
  end

  always_comb begin
    case (count[1:0])
      2'd0:    part_mask = 4'b0000;
      2'd1:    part_mask = 4'b0001;
      2'd2:    part_mask = 4'b0011;
      default: part_mask = 4'b0111;
    endcase
  end

  assign full = (count >= CW'(4));

  always_comb begin
    out_valid = 1'b0;
    out_mask  = 4'b0000;
    out_last  = 1'b0;
    if (state == S_RUN && full) begin
      out_valid = 1'b1;
      out_mask  = 4'b1111;
    end else if (state == S_DRAIN) begin
      out_valid = 1'b1;
      out_mask  = full ? 4'b1111 : part_mask;
      out_last  = (count <= CW'(4)) && !(|pipe);
    end
  end

  // Gated so the bus reads zero while idle rather than stale buffer contents.
  assign out_word  = out_valid ? rd_word : '0;
  assign handshake = out_valid && out_ready;
  assign pop_n     = handshake ? pop4(out_mask) : 3'd0;
  assign done      = (state == S_DONE);
  assign occupancy = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      last_issued <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + PW'(wr_n);
      rd_ptr <= rd_ptr + PW'(pop_n);
      count  <= count + CW'(wr_n) - CW'(pop_n);

      if (filt_issue && up_last)  last_issued <= 1'b1;
      else if (state == S_IDLE)   last_issued <= 1'b0;

      case (state)
        S_IDLE:  if (start) state <= S_RUN;
        S_RUN:   if (arrival && filt_last) state <= S_DRAIN;
        S_DRAIN: if (handshake && out_last) state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_filter_pack_ctrl.sv
//------------------------------------------------------------------------------
// tb_filter_pack_ctrl: scoreboard bench with a behavioural filter delay line
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_filter_pack_ctrl;

  localparam int WIDTH = 64;
  localparam int BUF_WORDS = 16;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic up_valid = 1'b0;
  logic up_last = 1'b0;
  logic out_ready = 1'b0;
  logic up_ready, filt_issue, out_valid, out_last, done, filt_last;
  logic [3:0] filt_valid, out_mask;
  logic [4*WIDTH-1:0] filt_word, out_word;
  logic [4:0] occupancy;

  filter_pack_ctrl #(.WIDTH(WIDTH), .BUF_WORDS(BUF_WORDS), .FILTER_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .up_valid(up_valid), .up_last(up_last),
    .up_ready(up_ready), .filt_issue(filt_issue), .filt_valid(filt_valid),
    .filt_word(filt_word), .filt_last(filt_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_word(out_word), .out_mask(out_mask),
    .out_last(out_last), .done(done), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [63:0]  exp_q[$];
  int           cur_n = 0;
  logic [63:0]  word_ctr = 64'hC0DE_0000_0000_1000;
  logic         iss_flag = 1'b0;
  logic         iss_last = 1'b0;
  int           iss_n = 0;
  logic [255:0] iss_words = '0;
  logic [LAT-1:0] dv;
  logic [LAT-1:0] dl;
  logic [2:0]   dn [LAT];
  logic [255:0] dw [LAT];
  int           beats = 0;
  logic [3:0]   last_mask = 4'hF;
  logic         prev_last_hs = 1'b0;
  int           rdy_mode = 1;

  // Filter model: fixed-latency delay line; garbage is presented on idle cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv <= '0;
      dl <= '0;
    end else begin
      dv <= {dv[LAT-2:0], iss_flag};
      dl <= {dl[LAT-2:0], iss_last};
      dn[0] <= 3'(iss_n);
      dw[0] <= iss_words;
      for (int k = 1; k < LAT; k++) begin
        dn[k] <= dn[k-1];
        dw[k] <= dw[k-1];
      end
    end
  end

  always_comb begin
    if (dv[LAT-1]) begin
      filt_valid = 4'((5'd1 << dn[LAT-1]) - 5'd1);
      filt_word  = dw[LAT-1];
      filt_last  = dl[LAT-1];
    end else begin
      filt_valid = 4'hF;
      filt_word  = {4{64'hDEAD_BEEF_0BAD_F00D}};
      filt_last  = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      iss_flag = 1'b0;
      prev_last_hs = 1'b0;
    end else begin
      iss_flag = filt_issue;
      iss_last = up_last;
      iss_n    = cur_n;
      if (filt_issue) begin
        for (int i = 0; i < cur_n; i++) begin
          iss_words[i*64 +: 64] = word_ctr;
          exp_q.push_back(word_ctr);
          word_ctr = word_ctr + 64'd1;
        end
      end
      check_val("occ_max", 64'(occupancy <= 5'd16), 64'd1);
      check_val("done", 64'(done), 64'(prev_last_hs));
      prev_last_hs = 1'b0;
      if (out_valid && out_ready) begin
        beats++;
        last_mask = out_mask;
        for (int i = 0; i < 4; i++) begin
          if (out_mask[i]) begin
            if (exp_q.size() == 0) check_val("underflow", 64'd1, 64'd0);
            else check_val("word", out_word[i*64 +: 64], exp_q.pop_front());
          end
        end
        if (!out_last) check_val("mid_mask", 64'(out_mask), 64'hF);
        else begin
          check_val("drain_empty", 64'(exp_q.size()), 64'd0);
          prev_last_hs = 1'b1;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    beats = 0;
    last_mask = 4'hF;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input int n, input bit last);
    int guard;
    guard = 0;
    cur_n = n;
    up_last = last;
    up_valid = 1'b1;
    do begin
      @(negedge clk);
      guard++;
    end while (!filt_issue && guard < 2000);
    if (!filt_issue) check_val("issue_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    up_valid = 1'b0;
    up_last = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < max_cyc && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) check_val("done_timeout", 64'd0, 64'd1);
    tick();
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int issued;
    repeat (2) @(negedge clk);
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_up_ready", 64'(up_ready), 64'd0);
    check_val("rst_done", 64'(done), 64'd0);
    check_val("rst_occ", 64'(occupancy), 64'd0);
    check_val("rst_mask", 64'(out_mask), 64'd0);
    rst_n = 1'b1;
    rdy_mode = 0;
    tick();
    tick();

    // Three full beats
    do_start();
    send(4, 0); send(4, 0); send(4, 1);
    wait_done(200);
    check_val("full3_beats", 64'(beats), 64'd3);
    check_val("full3_lastmask", 64'(last_mask), 64'hF);

    // 1 + 2 + 3 words -> one full beat and a 2-word tail
    do_start();
    send(1, 0); send(2, 0); send(3, 1);
    wait_done(200);
    check_val("part_beats", 64'(beats), 64'd2);
    check_val("part_lastmask", 64'(last_mask), 64'h3);

    // Single empty last beat
    do_start();
    send(0, 1);
    wait_done(200);
    check_val("empty_beats", 64'(beats), 64'd1);
    check_val("empty_lastmask", 64'(last_mask), 64'h0);

    // Backpressure: credit must stop issue at exactly a full buffer
    rdy_mode = 1;
    tick(); tick();
    do_start();
    cur_n = 4; up_last = 1'b0; up_valid = 1'b1;
    issued = 0;
    repeat (40) begin
      @(negedge clk);
      if (filt_issue) issued++;
    end
    check_val("bp_issued", 64'(issued), 64'd4);
    check_val("bp_up_ready", 64'(up_ready), 64'd0);
    check_val("bp_occ", 64'(occupancy), 64'd16);
    tick();
    up_valid = 1'b0;
    rdy_mode = 0;
    send(4, 0); send(4, 1);
    wait_done(300);
    check_val("bp_beats", 64'(beats), 64'd6);

    // Reset while stalled in the drain phase
    rdy_mode = 1;
    tick(); tick();
    do_start();
    send(4, 0); send(4, 1);
    repeat (10) tick();
    check_val("pre_rst_valid", 64'(out_valid), 64'd1);
    check_val("pre_rst_last", 64'(out_last), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_out_valid", 64'(out_valid), 64'd0);
    check_val("arst_up_ready", 64'(up_ready), 64'd0);
    check_val("arst_done", 64'(done), 64'd0);
    check_val("arst_occ", 64'(occupancy), 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    rdy_mode = 0;
    tick(); tick();
    do_start();
    send(4, 0); send(4, 0); send(4, 1);
    wait_done(200);
    check_val("post_rst_beats", 64'(beats), 64'd3);

    // Random word counts with random downstream stalls, wrapping the buffer
    rdy_mode = 2;
    do_start();
    for (int b = 0; b < 1000; b++) begin
      send($urandom_range(0, 4), b == 999);
      if ($urandom_range(0, 7) == 0) tick();
    end
    rdy_mode = 0;
    wait_done(500);
    check_val("rand_q_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
